// File: rtl/BG1_pkg.sv
// Base graph 1 column counts.
// Only the message-column count is needed by the accumulator path.
package BG1_pkg;
    localparam int BG1_MSG_COLS = 22;
    localparam int BG1_GAP_COLS = 4;
endpackage

// File: rtl/BG2_pkg.sv
// Base graph 2 column counts.
// Only the message-column count is needed by the accumulator path.
package BG2_pkg;
    localparam int BG2_MSG_COLS = 10;
    localparam int BG2_GAP_COLS = 4;
endpackage

// File: rtl/LDPC_pkg.sv
// Shared LDPC encoder widths, counts and the accumulator state type.
// The column counter must cover the widest message section of either base graph.
package LDPC_pkg;
    localparam int ZC_MAX              = 384;
    localparam int MUL_SH_BLOCKS_COUNT = 46;
    localparam int GAP_COLS_DEF        = 4;

    localparam int MSG_COLS_MAX =
        (BG1_pkg::BG1_MSG_COLS > BG2_pkg::BG2_MSG_COLS) ?
        BG1_pkg::BG1_MSG_COLS : BG2_pkg::BG2_MSG_COLS;
    localparam int COL_W_DEF = $clog2(MSG_COLS_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        MSG_ACC,
        GAP_WAIT,
        GAP_ACC,
        OUT
    } acc_state_t;
endpackage

// File: rtl/non_gap_parity_accumulator_if.sv
// Column-block input stream and parity result handshake.
// master drives blocks and accepts parities; slave is the accumulator.
interface non_gap_parity_accumulator_if
    import LDPC_pkg::*;
#(
    parameter int ZC_W       = ZC_MAX,
    parameter int NUM_BLOCKS = MUL_SH_BLOCKS_COUNT
);
    logic [NUM_BLOCKS-1:0][ZC_W-1:0] blk_in;
    logic                            blk_valid;
    logic                            blk_ready;
    logic [NUM_BLOCKS-1:0][ZC_W-1:0] parity_out;
    logic                            parity_valid;
    logic                            parity_ready;

    modport master (
        output blk_in, blk_valid, parity_ready,
        input  blk_ready, parity_out, parity_valid
    );

    modport slave (
        input  blk_in, blk_valid, parity_ready,
        output blk_ready, parity_out, parity_valid
    );
endinterface

// File: rtl/parity_row_acc.sv
// One parity row: masked XOR accumulation of shifted circulant blocks.
// Clear wins over accumulate so a new codeword never inherits old sums.
module parity_row_acc #(
    parameter int ZC_W = 384
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            en,
    input  logic [ZC_W-1:0] din,
    input  logic [ZC_W-1:0] mask,
    output logic [ZC_W-1:0] acc
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ (din & mask);
        end
    end
endmodule

// File: rtl/non_gap_parity_accumulator.sv
// Accumulates non-gap parity rows over message columns, then gap columns.
// Gap rows 0..GAP_COLS-1 are solved elsewhere and always read as zero here.
module non_gap_parity_accumulator
    import LDPC_pkg::*;
#(
    parameter int ZC_W       = ZC_MAX,
    parameter int NUM_BLOCKS = MUL_SH_BLOCKS_COUNT,
    parameter int GAP_COLS   = GAP_COLS_DEF,
    parameter int COL_W      = COL_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COL_W-1:0]         msg_cols,
    input  logic [ZC_W-1:0]          zc_mask,
    input  logic                     gap_done,
    output logic                     phase1_done,
    output logic                     busy,
    output logic [COL_W-1:0]         col_idx,
    non_gap_parity_accumulator_if.slave bus
);
    acc_state_t state_q;
    acc_state_t state_d;

    logic [COL_W-1:0] msg_cols_q;
    logic [COL_W-1:0] col_d;
    logic [ZC_W-1:0]  mask_q;
    logic             p1_d;
    logic             clr;
    logic             go;
    logic             beat;
    logic             acc_en;
    logic             rdy;

    logic [NUM_BLOCKS-1:0][ZC_W-1:0] acc;

    assign rdy    = (state_q == MSG_ACC) || (state_q == GAP_ACC);
    assign beat   = bus.blk_valid && rdy;
    assign acc_en = beat && !abort;

    always_comb begin
        state_d = state_q;
        col_d   = col_idx;
        p1_d    = 1'b0;
        clr     = 1'b0;
        go      = 1'b0;
        if (abort) begin
            state_d = IDLE;
            col_d   = '0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: go = start;
                MSG_ACC: begin
                    if (beat) begin
                        if (col_idx == msg_cols_q - COL_W'(1)) begin
                            state_d = GAP_WAIT;
                            col_d   = '0;
                            p1_d    = 1'b1;
                        end else begin
                            col_d = col_idx + COL_W'(1);
                        end
                    end
                end
                GAP_WAIT: begin
                    if (gap_done) state_d = GAP_ACC;
                end
                GAP_ACC: begin
                    if (beat) begin
                        if (col_idx == COL_W'(GAP_COLS - 1)) begin
                            state_d = OUT;
                            col_d   = '0;
                        end else begin
                            col_d = col_idx + COL_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.parity_ready) begin
                        state_d = IDLE;
                        go      = start;
                    end
                end
                default: state_d = IDLE;
            endcase
            // An empty message section skips straight to the gap phase.
            if (go) begin
                clr   = 1'b1;
                col_d = '0;
                if (msg_cols == '0) begin
                    state_d = GAP_WAIT;
                    p1_d    = 1'b1;
                end else begin
                    state_d = MSG_ACC;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            col_idx     <= '0;
            phase1_done <= 1'b0;
            msg_cols_q  <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_idx     <= col_d;
            phase1_done <= p1_d;
            if (go) begin
                msg_cols_q <= msg_cols;
                mask_q     <= zc_mask;
            end
        end
    end

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_row
        if (i < GAP_COLS) begin : g_gap
            assign acc[i] = '0;
        end else begin : g_acc
            parity_row_acc #(
                .ZC_W (ZC_W)
            ) u_row (
                .clk     (clk),
                .reset_n (reset_n),
                .clr     (clr),
                .en      (acc_en),
                .din     (bus.blk_in[i]),
                .mask    (mask_q),
                .acc     (acc[i])
            );
        end
    end

    assign bus.blk_ready    = rdy;
    assign bus.parity_valid = (state_q == OUT);
    assign bus.parity_out   = acc;
    assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_non_gap_parity_accumulator.sv
// Directed bench for the non-gap parity accumulator.
// A table of codewords plus hand sequences for abort and mid-codeword reset.
module tb_non_gap_parity_accumulator;
    import LDPC_pkg::*;

    localparam int ZW = ZC_MAX;
    localparam int NB = MUL_SH_BLOCKS_COUNT;
    localparam int GC = GAP_COLS_DEF;
    localparam int CW = COL_W_DEF;

    typedef logic [NB-1:0][ZW-1:0] blk_t;

    // mode 0 all-ones, 1 random; kind 0 model, 1 all zero, 2 mask in rows
    typedef struct {
        int mc;
        int zc;
        int mode;
        int stall;
        int gap_at;
        int exp_lat;
        int kind;
        int hold;
        bit chain;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          gap_done = 1'b0;
    logic [CW-1:0] msg_cols = '0;
    logic [ZW-1:0] zc_mask = '0;
    logic          phase1_done;
    logic          busy;
    logic [CW-1:0] col_idx;

    non_gap_parity_accumulator_if #(.ZC_W(ZW), .NUM_BLOCKS(NB)) bus ();

    non_gap_parity_accumulator #(
        .ZC_W       (ZW),
        .NUM_BLOCKS (NB),
        .GAP_COLS   (GC),
        .COL_W      (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .msg_cols    (msg_cols),
        .zc_mask     (zc_mask),
        .gap_done    (gap_done),
        .phase1_done (phase1_done),
        .busy        (busy),
        .col_idx     (col_idx),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    blk_t          model;
    logic [ZW-1:0] cur_mask;
    vec_t          tab[6];

    task automatic check(input string name, input bit ok,
                         input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic logic [ZW-1:0] mk_mask(input int zc);
        logic [ZW-1:0] m;
        m = '0;
        for (int i = 0; i < ZW; i++) if (i < zc) m[i] = 1'b1;
        return m;
    endfunction

    function automatic blk_t gen(input int mode);
        blk_t d;
        if (mode == 0) begin
            d = '1;
        end else begin
            for (int r = 0; r < NB; r++)
                for (int w = 0; w < ZW / 32; w++)
                    d[r][w*32 +: 32] = $urandom();
        end
        return d;
    endfunction

    function automatic int nz_rows(input blk_t a);
        int c;
        c = 0;
        for (int r = 0; r < NB; r++) if (a[r] != '0) c++;
        return c;
    endfunction

    function automatic int diff_rows(input blk_t a, input blk_t b);
        int c;
        c = 0;
        for (int r = 0; r < NB; r++) if (a[r] != b[r]) c++;
        return c;
    endfunction

    function automatic int exp_col(input int mc, input int beats);
        int b;
        if (beats < mc) return beats;
        b = beats - mc;
        if (b >= GC) return 0;
        return b;
    endfunction

    task automatic launch(input vec_t v);
        start    = 1'b1;
        msg_cols = CW'(v.mc);
        cur_mask = mk_mask(v.zc);
        zc_mask  = cur_mask;
        model    = '0;
        @(negedge clk);
        start            = 1'b0;
        bus.parity_ready = 1'b0;
    endtask

    task automatic run(input vec_t v, input int stop_n);
        int   n, beats, p1_cnt, p1_at, p1_exp, ov;
        bit   col_ok, gw_ok, hold_ok, ok;
        blk_t d, snap, ex;
        n = 0; beats = 0; p1_cnt = 0; p1_at = -1;
        p1_exp = (v.mc == 0) ? 0 : -1;
        col_ok = 1'b1; gw_ok = 1'b1;
        forever begin
            if (bus.parity_valid || n > 400 || n == stop_n) break;
            if (phase1_done) begin p1_cnt++; p1_at = n; end
            if (int'(col_idx) != exp_col(v.mc, beats)) col_ok = 1'b0;
            if (v.gap_at > 0 && beats == v.mc && n <= v.gap_at && bus.blk_ready)
                gw_ok = 1'b0;
            d             = gen(v.mode);
            bus.blk_in    = d;
            bus.blk_valid = ($urandom_range(99) >= v.stall);
            gap_done      = (n >= v.gap_at);
            start         = (v.stall > 0) && ($urandom_range(7) == 0);
            #1;
            if (bus.blk_valid && bus.blk_ready) begin
                for (int r = GC; r < NB; r++) model[r] = model[r] ^ (d[r] & cur_mask);
                beats++;
                if (beats == v.mc) p1_exp = n + 1;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; bus.blk_valid = 1'b0; gap_done = 1'b0;
        if (stop_n >= 0) return;

        check("valid_seen", bus.parity_valid, n, 400);
        if (v.exp_lat >= 0) check("latency", n == v.exp_lat, n, v.exp_lat);
        check("beats", beats == v.mc + GC, beats, v.mc + GC);
        check("p1_count", p1_cnt == 1, p1_cnt, 1);
        check("p1_cycle", p1_at == p1_exp, p1_at, p1_exp);
        check("col_idx", col_ok, col_ok, 1);
        if (v.gap_at > 0) check("gap_wait_ready", gw_ok, gw_ok, 1);
        check("parity_model", diff_rows(bus.parity_out, model) == 0,
              diff_rows(bus.parity_out, model), 0);
        ok = 1'b1;
        for (int r = 0; r < NB; r++) if ((bus.parity_out[r] & ~cur_mask) != '0) ok = 1'b0;
        check("upper_zero", ok, ok, 1);
        ok = 1'b1;
        for (int r = 0; r < GC; r++) if (bus.parity_out[r] != '0) ok = 1'b0;
        check("gap_rows_zero", ok, ok, 1);
        if (v.kind == 1)
            check("all_zero", bus.parity_out == '0, nz_rows(bus.parity_out), 0);
        if (v.kind == 2) begin
            ex = '0;
            for (int r = GC; r < NB; r++) ex[r] = cur_mask;
            check("mask_rows", diff_rows(bus.parity_out, ex) == 0,
                  diff_rows(bus.parity_out, ex), 0);
        end
        if (v.hold > 0) begin
            snap = bus.parity_out;
            hold_ok = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
                bus.blk_valid = 1'b1;
                bus.blk_in    = gen(1);
                @(negedge clk);
                if (bus.parity_out != snap || !bus.parity_valid) hold_ok = 1'b0;
            end
            bus.blk_valid = 1'b0;
            check("hold_stable", hold_ok, hold_ok, 1);
        end
    endtask

    task automatic accept(input bit chain, input vec_t nxt);
        bus.parity_ready = 1'b1;
        if (chain) begin
            launch(nxt);
            check("chain_start", bus.blk_ready && busy && !bus.parity_valid,
                  bus.blk_ready, 1);
        end else begin
            @(negedge clk);
            bus.parity_ready = 1'b0;
            check("idle_after", !busy && !bus.parity_valid, busy, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t va, vb, vr;
        tab[0] = '{BG1_pkg::BG1_MSG_COLS, 384, 0, 0, 0, 27, 1, 0, 1'b0};
        tab[1] = '{BG2_pkg::BG2_MSG_COLS, 52, 1, 0, 0, 15, 0, 0, 1'b0};
        tab[2] = '{0, 384, 1, 0, 10, 15, 0, 0, 1'b0};
        tab[3] = '{1, 96, 0, 0, 0, 6, 2, 0, 1'b0};
        tab[4] = '{7, 200, 1, 40, 0, -1, 0, 5, 1'b1};
        tab[5] = '{31, 384, 1, 20, 50, -1, 0, 0, 1'b0};

        bus.blk_in = '0;
        bus.blk_valid = 1'b0;
        bus.parity_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_outputs",
              !busy && !bus.blk_ready && !bus.parity_valid && !phase1_done &&
              col_idx == '0 && bus.parity_out == '0, busy, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (i == 0 || !tab[i-1].chain) launch(tab[i]);
            run(tab[i], -1);
            accept(tab[i].chain, (i < 5) ? tab[i+1] : tab[i]);
        end

        va = '{10, 384, 1, 0, 0, -1, 0, 0, 1'b0};
        launch(va);
        run(va, 5);
        abort = 1'b1; start = 1'b1; bus.blk_valid = 1'b1; msg_cols = CW'(3);
        @(negedge clk);
        check("abort_idle",
              !busy && !bus.blk_ready && !bus.parity_valid && !phase1_done &&
              col_idx == '0 && bus.parity_out == '0, nz_rows(bus.parity_out), 0);
        abort = 1'b0; start = 1'b0; bus.blk_valid = 1'b0;
        @(negedge clk);
        vb = '{3, 128, 1, 0, 0, 8, 0, 0, 1'b0};
        launch(vb);
        run(vb, -1);
        accept(1'b0, vb);

        vr = '{2, 384, 0, 0, 0, -1, 0, 0, 1'b0};
        launch(vr);
        run(vr, 4);
        check("in_gap_acc", bus.blk_ready && int'(col_idx) == 1, col_idx, 1);
        reset_n = 1'b0;
        #1;
        check("reset_mid",
              !busy && !bus.blk_ready && !bus.parity_valid && !phase1_done &&
              col_idx == '0 && bus.parity_out == '0, nz_rows(bus.parity_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vr = '{2, 384, 0, 0, 0, 7, 1, 0, 1'b0};
        launch(vr);
        run(vr, -1);
        accept(1'b0, vr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/non_gap_parity_accumulator.md
NON_GAP_PARITY_ACCUMULATOR -- requirements
Module: non_gap_parity_accumulator

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ZC_W, 384, maximum lifting size; width of one circulant block.
- NUM_BLOCKS, 46, parity rows held, equal to the package MUL_SH_BLOCKS_COUNT.
- GAP_COLS, 4, number of gap (core) parity columns and rows.
- COL_W, 5, width of the column counter and of msg_cols.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a new codeword.
- abort, input, 1, synchronous cancel.
- msg_cols, input, COL_W, message columns for this codeword, sampled at start.
- zc_mask, input, ZC_W, ones in bits [Zc-1:0], sampled at start.
- blk_in, input, NUM_BLOCKS x ZC_W, shifted contribution of one column for every row.
- blk_valid, input, 1, blk_in is valid.
- blk_ready, output, 1, the block accepts blk_in.
- gap_done, input, 1, gap parities are available.
- phase1_done, output, 1, one-cycle pulse when message accumulation ends.
- parity_out, output, NUM_BLOCKS x ZC_W, accumulated non-gap parities.
- parity_valid, output, 1, parity_out is final.
- parity_ready, input, 1, the consumer accepts parity_out.
- busy, output, 1, the state is not IDLE.
- col_idx, output, COL_W, index of the current column in the active phase.

Function
REQ-003 The FSM SHALL have the states IDLE, MSG_ACC, GAP_WAIT, GAP_ACC and OUT.
REQ-004 A beat SHALL be the condition blk_valid && blk_ready.
REQ-005 blk_ready SHALL be 1 only in MSG_ACC and GAP_ACC.
REQ-006 In IDLE, start SHALL latch msg_cols and zc_mask, clear all accumulators and col_idx, and go to MSG_ACC; if msg_cols is 0 it SHALL go to GAP_WAIT instead.
REQ-007 On each beat in MSG_ACC, rows GAP_COLS..NUM_BLOCKS-1 SHALL update as acc[i] <= acc[i] ^ (blk_in[i] & mask); rows 0..GAP_COLS-1 SHALL be unchanged.
REQ-008 Each beat SHALL increment col_idx; the beat where col_idx == msg_cols-1 SHALL go to GAP_WAIT, reset col_idx to 0, and pulse phase1_done in the next cycle.
REQ-009 GAP_WAIT SHALL hold the accumulators; gap_done SHALL move the state to GAP_ACC, including when gap_done is already high on entry.
REQ-010 On each beat in GAP_ACC, the update SHALL be the same as REQ-007; after GAP_COLS beats the state SHALL go to OUT.
REQ-011 parity_valid SHALL rise in the cycle after the last GAP_ACC beat, and parity_out SHALL stay stable while parity_valid is high.
REQ-012 parity_out SHALL equal acc at all times; rows 0..GAP_COLS-1 SHALL always read 0.
REQ-013 In OUT, parity_ready SHALL go to IDLE; if start is also asserted in that cycle, the state SHALL go directly to MSG_ACC (or GAP_WAIT when msg_cols is 0) with the accumulators cleared.
REQ-014 start SHALL be ignored in every state other than IDLE and OUT.
REQ-015 In any state, abort SHALL clear the accumulators, col_idx and outputs and go to IDLE; abort SHALL take priority over every other input.
REQ-016 blk_valid without blk_ready SHALL have no effect; stalls of any length SHALL be tolerated.

Reset
REQ-017 reset_n low SHALL asynchronously force:
- state = IDLE;
- accumulators, parity_out and col_idx = 0;
- blk_ready, phase1_done, parity_valid and busy = 0.
REQ-018 Reset mid-codeword SHALL discard all partial sums; the first start after release SHALL begin a clean codeword.

Structure
REQ-019 The state enum and the defaults for ZC_W, NUM_BLOCKS and GAP_COLS SHALL live in LDPC_pkg; BG-specific column counts SHALL stay in BG1_pkg and BG2_pkg.
REQ-020 The per-row masked XOR accumulate SHALL be one sub-module, parity_row_acc, instantiated NUM_BLOCKS-GAP_COLS times; the FSM and counter SHALL stay in the top module.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- BG1 case: msg_cols=22, Zc=384, all-ones blk_in each beat, gap_done immediate -> parity_valid 27 cycles after start; non-gap rows equal 26 XORs of all-ones, which is 0.
- Zc=52, zc_mask=52 ones, random blk_in -> upper bits [383:52] of every row are 0; lower bits match a reference model.
- msg_cols=0 -> phase1_done, then GAP_ACC only; gap_done delayed 10 cycles -> blk_ready stays 0 throughout GAP_WAIT.
- Random blk_valid stalls plus parity_ready held low for 5 cycles -> parity_out stable while held; start in the accept cycle begins the next codeword with cleared sums.
- abort in mid MSG_ACC, and separately reset_n low in GAP_ACC -> IDLE, all outputs 0; the next codeword result is correct.
